// File: rtl/hyper_rx_packer.sv
// Receive-side packer: folds unstallable 16-bit PHY read beats into byte-strobed
// 32-bit words and pushes them, through a two-entry buffer, into the CDC FIFO source port.
module hyper_rx_packer #(
    parameter int LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cfg_start_i,
    input  logic [1:0]       cfg_addr_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             phy_valid_i,
    input  logic [15:0]      phy_data_i,
    output logic             dst_valid_o,
    input  logic             dst_ready_i,
    output logic [31:0]      dst_data_o,
    output logic [3:0]       dst_strb_o,
    output logic             dst_last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overflow_o,
    output logic [1:0]       dbg_state_o
);

    // dst handshake: a word transfers on a cycle where dst_valid_o && dst_ready_i;
    // once raised, dst_valid_o and the payload hold until that transfer happens.

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PACK  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_remaining;
    logic [1:0]       r_lane;
    logic             r_skip_low;
    logic [31:0]      r_asm_data;
    logic [3:0]       r_asm_strb;
    logic             r_zero_done;

    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic [3:0]       r_out_strb;
    logic             r_out_last;
    logic             r_skid_valid;
    logic [31:0]      r_skid_data;
    logic [3:0]       r_skid_strb;
    logic             r_skid_last;
    logic             r_overflow;

    logic             w_beat;
    logic             w_b0_take;
    logic             w_b1_take;
    logic [LEN_W-1:0] w_rem1;
    logic [LEN_W-1:0] w_rem2;
    logic [1:0]       w_lane1;
    logic [1:0]       w_lane2;
    logic [31:0]      w_asm_data;
    logic [3:0]       w_asm_strb;
    logic             w_word_done;
    logic             w_word_last;
    logic             w_pop;
    logic             w_drop;
    logic             w_start_ok;

    // Low byte is placed first, then the high byte; each step consumes one length unit.
    always_comb begin
        w_beat     = phy_valid_i && (r_state == ST_PACK);
        w_b0_take  = w_beat && !r_skip_low && (r_remaining != '0);
        w_rem1     = r_remaining - LEN_W'(w_b0_take);
        w_lane1    = r_lane + 2'(w_b0_take);
        w_b1_take  = w_beat && (w_rem1 != '0);
        w_rem2     = w_rem1 - LEN_W'(w_b1_take);
        w_lane2    = w_lane1 + 2'(w_b1_take);
        w_asm_data = r_asm_data;
        w_asm_strb = r_asm_strb;
        if (w_b0_take) begin
            w_asm_data[{r_lane, 3'b000} +: 8] = phy_data_i[7:0];
            w_asm_strb[r_lane]                = 1'b1;
        end
        if (w_b1_take) begin
            w_asm_data[{w_lane1, 3'b000} +: 8] = phy_data_i[15:8];
            w_asm_strb[w_lane1]                = 1'b1;
        end
        // At most two bytes per beat, so lane landing on 0 after a take means it wrapped.
        w_word_done = (w_b0_take || w_b1_take) && ((w_rem2 == '0) || (w_lane2 == 2'd0));
        w_word_last = (w_rem2 == '0);
    end

    assign w_pop      = r_out_valid && dst_ready_i;
    assign w_drop     = w_word_done && !w_pop && r_out_valid && r_skid_valid;
    assign w_start_ok = cfg_start_i && (r_state == ST_IDLE) && (cfg_len_i != '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_lane      <= 2'd0;
            r_skip_low  <= 1'b0;
            r_asm_data  <= 32'd0;
            r_asm_strb  <= 4'd0;
            r_zero_done <= 1'b0;
        end else begin
            r_zero_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cfg_start_i) begin
                        if (cfg_len_i == '0) begin
                            r_zero_done <= 1'b1;
                        end else begin
                            r_remaining <= cfg_len_i;
                            r_lane      <= cfg_addr_i;
                            r_skip_low  <= cfg_addr_i[0];
                            r_asm_data  <= 32'd0;
                            r_asm_strb  <= 4'd0;
                            r_state     <= ST_PACK;
                        end
                    end
                end
                ST_PACK: begin
                    if (w_beat) begin
                        r_remaining <= w_rem2;
                        r_lane      <= w_lane2;
                        r_skip_low  <= 1'b0;
                        if (w_word_done) begin
                            r_asm_data <= 32'd0;
                            r_asm_strb <= 4'd0;
                            // A dropped last word can never be accepted, so skip DRAIN.
                            if (w_word_last) begin
                                r_state <= w_drop ? ST_IDLE : ST_DRAIN;
                            end
                        end else begin
                            r_asm_data <= w_asm_data;
                            r_asm_strb <= w_asm_strb;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_pop && r_out_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Output register plus skid entry; the skid always holds the younger word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= 32'd0;
            r_out_strb   <= 4'd0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'd0;
            r_skid_strb  <= 4'd0;
            r_skid_last  <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_overflow <= 1'b0;
            end
            if (w_pop) begin
                if (r_skid_valid) begin
                    r_out_data <= r_skid_data;
                    r_out_strb <= r_skid_strb;
                    r_out_last <= r_skid_last;
                    if (w_word_done) begin
                        r_skid_data <= w_asm_data;
                        r_skid_strb <= w_asm_strb;
                        r_skid_last <= w_word_last;
                    end else begin
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_word_done) begin
                    r_out_data <= w_asm_data;
                    r_out_strb <= w_asm_strb;
                    r_out_last <= w_word_last;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_word_done) begin
                if (!r_out_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_asm_data;
                    r_out_strb  <= w_asm_strb;
                    r_out_last  <= w_word_last;
                end else if (!r_skid_valid) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= w_asm_data;
                    r_skid_strb  <= w_asm_strb;
                    r_skid_last  <= w_word_last;
                end else begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign dst_valid_o = r_out_valid;
    assign dst_data_o  = r_out_data;
    assign dst_strb_o  = r_out_strb;
    assign dst_last_o  = r_out_last;
    assign busy_o      = (r_state != ST_IDLE);
    assign done_o      = r_zero_done || ((r_state == ST_DRAIN) && w_pop && r_out_last);
    assign overflow_o  = r_overflow;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_hyper_rx_packer.sv
// Bench for hyper_rx_packer: directed transfers plus randomized transfers with
// random FIFO backpressure, scored against an address-based byte model.
module tb_hyper_rx_packer;

    localparam int LEN_W = 16;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             cfg_start_i = 1'b0;
    logic [1:0]       cfg_addr_i = 2'd0;
    logic [LEN_W-1:0] cfg_len_i = '0;
    logic             phy_valid_i = 1'b0;
    logic [15:0]      phy_data_i = 16'd0;
    logic             dst_ready_i = 1'b0;
    logic             dst_valid_o;
    logic [31:0]      dst_data_o;
    logic [3:0]       dst_strb_o;
    logic             dst_last_o;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;
    logic [1:0]       dbg_state_o;

    int n_checks = 0;
    int n_errors = 0;
    int n_done = 0;
    int n_done_exp = 0;
    bit zl_mode = 1'b0;
    bit rr_stop = 1'b0;
    logic [36:0] exp_q[$];

    hyper_rx_packer #(.LEN_W(LEN_W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cfg_start_i (cfg_start_i),
        .cfg_addr_i  (cfg_addr_i),
        .cfg_len_i   (cfg_len_i),
        .phy_valid_i (phy_valid_i),
        .phy_data_i  (phy_data_i),
        .dst_valid_o (dst_valid_o),
        .dst_ready_i (dst_ready_i),
        .dst_data_o  (dst_data_o),
        .dst_strb_o  (dst_strb_o),
        .dst_last_o  (dst_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .overflow_o  (overflow_o),
        .dbg_state_o (dbg_state_o)
    );

    // clock / watchdog
    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard monitor: samples on the falling edge
    initial begin : monitor
        logic [36:0] held;
        logic [36:0] item;
        bit stalled;
        stalled = 1'b0;
        held = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                stalled = 1'b0;
                continue;
            end
            if (stalled) begin
                check_val("hold_valid", dst_valid_o, 1);
                check_val("hold_word", {dst_last_o, dst_strb_o, dst_data_o}, held);
            end
            if (dst_valid_o && dst_ready_i) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_word", exp_q.size(), 1);
                end else begin
                    item = exp_q.pop_front();
                    check_val("word", {dst_last_o, dst_strb_o, dst_data_o}, item);
                end
            end
            stalled = dst_valid_o && !dst_ready_i;
            held = {dst_last_o, dst_strb_o, dst_data_o};
            if (done_o) begin
                n_done++;
                if (!zl_mode) begin
                    check_val("done_on_last", {dst_valid_o, dst_ready_i, dst_last_o}, 3'b111);
                end
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic start(input int addr, input int len);
        cfg_start_i = 1'b1;
        cfg_addr_i  = 2'(addr);
        cfg_len_i   = LEN_W'(len);
        tick();
        cfg_start_i = 1'b0;
    endtask

    task automatic beat(input logic [15:0] d);
        phy_valid_i = 1'b1;
        phy_data_i  = d;
        tick();
        phy_valid_i = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (n_done < n_done_exp && k < budget) begin
            tick();
            k++;
        end
        check_val("done_count", n_done, n_done_exp);
    endtask

    task automatic push_exp(input logic last, input logic [3:0] strb, input logic [31:0] data);
        exp_q.push_back({last, strb, data});
    endtask

    // Byte model: requested address a goes to lane a%4, words break at lane 3 or the final byte.
    task automatic model_push(input int addr, input int len, input logic [15:0] beats[$]);
        int base;
        int off;
        int a;
        int lane;
        logic [31:0] w;
        logic [3:0] s;
        logic [15:0] b;
        logic [7:0] by;
        base = addr & ~1;
        w = '0;
        s = '0;
        for (int i = 0; i < len; i++) begin
            a = addr + i;
            off = a - base;
            b = beats[off / 2];
            by = (off % 2 == 1) ? b[15:8] : b[7:0];
            lane = a % 4;
            w[lane*8 +: 8] = by;
            s[lane] = 1'b1;
            if (lane == 3 || i == len - 1) begin
                push_exp(i == len - 1, s, w);
                w = '0;
                s = '0;
            end
        end
    endtask

    task automatic run_random();
        int addr;
        int len;
        int nb;
        logic [15:0] beats[$];
        addr = $urandom_range(0, 3);
        len = $urandom_range(1, 20);
        nb = ((addr % 2) + len + 1) / 2;
        for (int i = 0; i < nb; i++) beats.push_back(16'($urandom));
        model_push(addr, len, beats);
        n_done_exp++;
        rr_stop = 1'b0;
        fork
            begin
                while (!rr_stop) begin
                    dst_ready_i = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join_none
        start(addr, len);
        for (int i = 0; i < nb; i++) begin
            beat(beats[i]);
            idle($urandom_range(1, 2));
        end
        wait_done(300);
        rr_stop = 1'b1;
        idle(2);
        dst_ready_i = 1'b1;
        check_val("rnd_q_empty", exp_q.size(), 0);
        check_val("rnd_overflow", overflow_o, 0);
    endtask

    initial begin
        // reset
        dst_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_valid", dst_valid_o, 0);
        check_val("rst_data", dst_data_o, 0);
        check_val("rst_strb", dst_strb_o, 0);
        check_val("rst_last", dst_last_o, 0);
        check_val("rst_busy", busy_o, 0);
        check_val("rst_done", done_o, 0);
        check_val("rst_ovf", overflow_o, 0);
        check_val("rst_state", dbg_state_o, 0);
        rst_ni = 1'b1;
        idle(2);

        // aligned, no backpressure
        push_exp(1'b0, 4'hF, 32'h33221100);
        push_exp(1'b1, 4'hF, 32'h77665544);
        n_done_exp++;
        start(0, 8);
        check_val("t1_busy", busy_o, 1);
        beat(16'h1100);
        check_val("t1_lat_pre", dst_valid_o, 0);
        beat(16'h3322);
        check_val("t1_lat_valid", dst_valid_o, 1);
        check_val("t1_lat_data", dst_data_o, 32'h33221100);
        beat(16'h5544);
        beat(16'h7766);
        wait_done(20);
        idle(1);
        check_val("t1_idle", busy_o, 0);

        // odd start, short length
        push_exp(1'b0, 4'hE, 32'h33221100);
        push_exp(1'b1, 4'h1, 32'h00000044);
        n_done_exp++;
        start(1, 4);
        beat(16'h1100);
        beat(16'h3322);
        beat(16'h5544);
        wait_done(20);

        // length ending mid-beat
        push_exp(1'b0, 4'hC, 32'hBBAA0000);
        push_exp(1'b1, 4'h1, 32'h000000CC);
        n_done_exp++;
        start(2, 3);
        beat(16'hBBAA);
        beat(16'hDDCC);
        wait_done(20);
        idle(2);
        check_val("t3_q_empty", exp_q.size(), 0);

        // backpressure and overflow
        dst_ready_i = 1'b0;
        push_exp(1'b0, 4'hF, 32'h03020100);
        push_exp(1'b0, 4'hF, 32'h07060504);
        n_done_exp++;
        start(0, 16);
        for (int i = 0; i < 6; i++) beat(16'h0100 + 16'(i) * 16'h0202);
        check_val("t4_ovf_set", overflow_o, 1);
        check_val("t4_head_valid", dst_valid_o, 1);
        check_val("t4_head_data", dst_data_o, 32'h03020100);
        idle(3);
        check_val("t4_ovf_sticky", overflow_o, 1);
        dst_ready_i = 1'b1;
        idle(3);
        check_val("t4_drained", exp_q.size(), 0);
        push_exp(1'b1, 4'hF, 32'h0F0E0D0C);
        beat(16'h0D0C);
        beat(16'h0F0E);
        wait_done(20);
        check_val("t4_ovf_after", overflow_o, 1);

        // zero length
        zl_mode = 1'b1;
        n_done_exp++;
        start(0, 0);
        check_val("zl_done", done_o, 1);
        check_val("zl_busy", busy_o, 0);
        check_val("zl_valid", dst_valid_o, 0);
        tick();
        check_val("zl_done_end", done_o, 0);
        check_val("zl_valid2", dst_valid_o, 0);
        zl_mode = 1'b0;

        // start while busy is ignored; also clears overflow on the accepted start
        push_exp(1'b1, 4'hF, 32'h33221100);
        n_done_exp++;
        start(0, 4);
        check_val("sb_ovf_clr", overflow_o, 0);
        beat(16'h1100);
        cfg_start_i = 1'b1;
        cfg_addr_i = 2'd3;
        cfg_len_i = LEN_W'(8);
        tick();
        cfg_start_i = 1'b0;
        check_val("sb_state", dbg_state_o, 1);
        beat(16'h3322);
        wait_done(20);

        // reset mid-transfer
        start(0, 8);
        beat(16'h1100);
        rst_ni = 1'b0;
        #1;
        check_val("mr_busy", busy_o, 0);
        check_val("mr_valid", dst_valid_o, 0);
        check_val("mr_done", done_o, 0);
        check_val("mr_ovf", overflow_o, 0);
        check_val("mr_state", dbg_state_o, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        push_exp(1'b1, 4'hF, 32'hDDCCBBAA);
        n_done_exp++;
        start(0, 4);
        beat(16'hBBAA);
        beat(16'hDDCC);
        wait_done(20);

        // randomized transfers with random backpressure
        for (int r = 0; r < 8; r++) run_random();

        idle(4);
        check_val("done_total", n_done, n_done_exp);
        check_val("q_final", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
